sys_timer: RTL and testbench
============================

Name: sys_timer

Overview:
- Owns the user-visible 64-bit performance and time counters: cycle, time and instret.
- Serves the CSR unit's read selection (timer + upper/lower half) with a zero-latency read mux.
- Sequences counter updates: per-clock cycle count, prescaled time count, and instret on retirement.
- Accepts a privileged write port so machine-level software or debug can preset any counter half.

Parameters:
- TIME_DIV, 1, core clocks per time increment; must be >= 1; 1 means time increments every clock.
- DIV_W, 16, width of the prescaler counter; TIME_DIV must be <= 2**DIV_W.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- timer  input  2  read select: 0=CYCLE, 1=TIME, 2=INSTRET, 3=reserved.
- upper  input  1  read half select: 1 = bits 63:32, 0 = bits 31:0.
- data  output  32  selected counter half.
- instr_retired  input  1  pulse: one instruction retired this cycle.
- halt  input  1  freeze cycle and instret counting (debug halt); time keeps running.
- wr_en  input  1  counter write strobe.
- wr_timer  input  2  write target, same encoding as timer.
- wr_upper  input  1  write half select.
- wr_data  input  32  write value.

Behaviour:
- Reset (async assert, sync release): cycle, time, instret, prescaler and snapshot register all 0. data reflects the registers, so it reads 0.
- Read path is combinational, with 0-cycle latency from timer/upper to data. It shows register values as of the last clock edge. timer=3 gives data=0.
- cycle: +1 every clock while halt=0.
- instret: +1 on a clock edge with instr_retired=1 and halt=0.
- Prescaler counts 0..TIME_DIV-1. When it equals TIME_DIV-1 it wraps to 0 and time +1 on that edge. With TIME_DIV=1, time +1 every clock. Prescaler and time ignore halt.
- All counters are full 64-bit with carry from low to high half. 0xFFFF_FFFF_FFFF_FFFF + 1 wraps to 0 with no flag.
- Write:
  - wr_en=1 replaces the selected 32-bit half with wr_data at the next edge.
  - The other half keeps its pre-edge value.
  - The targeted counter does not increment on that edge: write beats increment, no carry generated.
  - Non-targeted counters update normally.
  - wr_timer=3: write ignored.
  - Writing either half of time also clears the prescaler to 0.
- Simultaneous events:
  - instr_retired together with a write to a different counter: both take effect.
  - Read and write to the same half in one cycle: data shows the old value; the new value is visible from the next cycle.
- Reset mid-operation: all state returns to 0 immediately (asynchronous); no partial write survives.

Optional Feature:
SYS_TIMER_SNAPSHOT_EN
- Defined:
  - The first cycle in which timer!=3 and upper=0 captures the selected counter's pre-edge bits 63:32 into a per-counter shadow register at the clock edge.
  - The "first cycle" is the rising edge of the condition, tracked with a registered previous-select.
  - Reads with upper=1 then return the shadow for that counter instead of the live high half.
  - This gives a consistent 64-bit value for lo-then-hi read sequences.
  - Any write to a counter also updates that counter's shadow with its new high half.
  - Shadows reset to 0.
- Undefined:
  - No shadows are implemented; upper=1 always returns the live high half.

Test Plan:
- Reset, then release, 10 clocks with halt=0, timer=0 upper=0 -> data=10. Read timer=1 with TIME_DIV=4 -> data=2. Read timer=2 -> data=0.
- Pulse instr_retired for 5 cycles with halt=1 on 2 of them -> instret low=3. Cycle counter does not advance during those 2 halted cycles.
- Write cycle low=0xFFFF_FFFE, high=0: read low=0xFFFF_FFFF one clock later. After the next clock, low=0 and high=1.
- Write instret high=0xFFFF_FFFF, low=0xFFFF_FFFF, then one retire -> both halves 0.
- With SYS_TIMER_SNAPSHOT_EN, set cycle=0x0000_0000_FFFF_FFFF. Read low at that edge, wait 1 clock (carry into high), read high -> 0 (shadow). Without the macro -> 1.
- Write time low=100 with prescaler mid-count, TIME_DIV=4 -> time stays 100 for exactly 4 clocks, then 101. Assert reset mid-count -> data=0 immediately, before any clock edge.

Source files
------------

// File: rtl/sys_timer.sv
// sys_timer: 64-bit cycle/time/instret counters with CSR read mux and write port.
// Optional define SYS_TIMER_SNAPSHOT_EN adds per-counter high-half shadows.
module sys_timer #(
  parameter int unsigned TIME_DIV = 1,
  parameter int unsigned DIV_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  timer,
  input  logic        upper,
  output logic [31:0] data,
  input  logic        instr_retired,
  input  logic        halt,
  input  logic        wr_en,
  input  logic [1:0]  wr_timer,
  input  logic        wr_upper,
  input  logic [31:0] wr_data
);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TIME_DIV - 1);

  logic [63:0]      cnt_q [3];
  logic [63:0]      cnt_d [3];
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [2:0]       inc;
  logic [2:0]       hit;
  logic             tick;
  logic [31:0]      rd_lo;
  logic [31:0]      rd_hi;

  // Counter next-state: a write to a half beats that counter's increment
  always_comb begin
    tick = (div_q == DIV_MAX);
    inc  = {instr_retired & ~halt, tick, ~halt};
    for (int i = 0; i < 3; i++) begin
      hit[i]   = wr_en && (wr_timer == 2'(i));
      cnt_d[i] = cnt_q[i] + {63'd0, inc[i]};
      if (hit[i]) begin
        cnt_d[i] = cnt_q[i];
        if (wr_upper) begin
          cnt_d[i][63:32] = wr_data;
        end else begin
          cnt_d[i][31:0] = wr_data;
        end
      end
    end
    div_d = (tick || hit[1]) ? '0 : div_q + DIV_W'(1);
  end

  // Counter and prescaler registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      div_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      div_q <= div_d;
    end
  end

`ifdef SYS_TIMER_SNAPSHOT_EN
  logic [31:0] shd_q [3];
  logic [31:0] shd_d [3];
  logic        pc_q;
  logic        pc_d;
  logic [1:0]  pt_q;
  logic        cap;

  // Shadow update: capture high half on the first low-half read of a counter
  always_comb begin
    pc_d = (timer != 2'd3) && !upper;
    cap  = pc_d && !(pc_q && (pt_q == timer));
    for (int i = 0; i < 3; i++) begin
      shd_d[i] = shd_q[i];
      if (cap && (timer == 2'(i))) begin
        shd_d[i] = cnt_q[i][63:32];
      end
      if (hit[i]) begin
        shd_d[i] = cnt_d[i][63:32];
      end
    end
  end

  // Shadow and previous-select registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        shd_q[i] <= '0;
      end
      pc_q <= 1'b0;
      pt_q <= 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        shd_q[i] <= shd_d[i];
      end
      pc_q <= pc_d;
      pt_q <= timer;
    end
  end
`endif

  // Zero-latency read mux; reserved select reads as zero
  always_comb begin
    rd_lo = '0;
    rd_hi = '0;
    case (timer)
      2'd0: begin
        rd_lo = cnt_q[0][31:0];
`ifdef SYS_TIMER_SNAPSHOT_EN
        rd_hi = shd_q[0];
`else
        rd_hi = cnt_q[0][63:32];
`endif
      end
      2'd1: begin
        rd_lo = cnt_q[1][31:0];
`ifdef SYS_TIMER_SNAPSHOT_EN
        rd_hi = shd_q[1];
`else
        rd_hi = cnt_q[1][63:32];
`endif
      end
      2'd2: begin
        rd_lo = cnt_q[2][31:0];
`ifdef SYS_TIMER_SNAPSHOT_EN
        rd_hi = shd_q[2];
`else
        rd_hi = cnt_q[2][63:32];
`endif
      end
      default: begin
        rd_lo = '0;
        rd_hi = '0;
      end
    endcase
    data = upper ? rd_hi : rd_lo;
  end

endmodule

// File: tb/tb_sys_timer.sv
// tb_sys_timer: random and directed stimulus against a behavioural counter model.
// Honours SYS_TIMER_SNAPSHOT_EN the same way as the design.
module tb_sys_timer;

  localparam int TDIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  timer = 2'd0;
  logic        upper = 1'b0;
  logic [31:0] data;
  logic        instr_retired = 1'b0;
  logic        halt = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_timer = 2'd0;
  logic        wr_upper = 1'b0;
  logic [31:0] wr_data = 32'd0;

  int checks = 0;
  int errors = 0;

  int          req_id = 0;
  int          seen_id = 0;
  logic [31:0] req_val = 32'd0;
  string       req_nm = "";

  sys_timer #(.TIME_DIV(TDIV), .DIV_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .timer(timer),
    .upper(upper),
    .data(data),
    .instr_retired(instr_retired),
    .halt(halt),
    .wr_en(wr_en),
    .wr_timer(wr_timer),
    .wr_upper(wr_upper),
    .wr_data(wr_data)
  );

  always #10 clk = ~clk;

  // Behavioural model: three 64-bit integers plus a clock phase for time
  longint unsigned m_cnt [3];
  longint unsigned n_cnt [3];
  int              m_phase;
`ifdef SYS_TIMER_SNAPSHOT_EN
  logic [31:0] m_shd [3];
  logic        m_pc;
  logic [1:0]  m_pt;
`endif

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_phase = 0;
`ifdef SYS_TIMER_SNAPSHOT_EN
      for (int i = 0; i < 3; i++) m_shd[i] = 32'd0;
      m_pc = 1'b0;
      m_pt = 2'd0;
`endif
    end else begin
      n_cnt[0] = m_cnt[0] + (halt ? 64'd0 : 64'd1);
      n_cnt[1] = m_cnt[1] + ((m_phase == TDIV - 1) ? 64'd1 : 64'd0);
      n_cnt[2] = m_cnt[2] + ((instr_retired && !halt) ? 64'd1 : 64'd0);
      m_phase = (m_phase + 1) % TDIV;
      if (wr_en && wr_timer != 2'd3) begin
        if (wr_upper) n_cnt[wr_timer] = {wr_data, m_cnt[wr_timer][31:0]};
        else          n_cnt[wr_timer] = {m_cnt[wr_timer][63:32], wr_data};
        if (wr_timer == 2'd1) m_phase = 0;
      end
`ifdef SYS_TIMER_SNAPSHOT_EN
      if (timer != 2'd3 && !upper && !(m_pc && m_pt == timer))
        m_shd[timer] = m_cnt[timer][63:32];
      if (wr_en && wr_timer != 2'd3)
        m_shd[wr_timer] = n_cnt[wr_timer][63:32];
      m_pc = (timer != 2'd3) && !upper;
      m_pt = timer;
`endif
      for (int i = 0; i < 3; i++) m_cnt[i] = n_cnt[i];
    end
  end

  function automatic logic [31:0] exp_data();
    if (timer == 2'd3) return 32'd0;
    if (!upper) return m_cnt[timer][31:0];
`ifdef SYS_TIMER_SNAPSHOT_EN
    return m_shd[timer];
`else
    return m_cnt[timer][63:32];
`endif
  endfunction

  // Compare process: model check every falling edge, literal checks on request
  always @(negedge clk or req_id) begin
    logic [31:0] e;
    if (req_id != seen_id) begin
      seen_id = req_id;
      checks++;
      if (data !== req_val) begin
        errors++;
        $display("FAIL %s: data=%h expected %h", req_nm, data, req_val);
      end
    end else if (clk == 1'b0) begin
      e = exp_data();
      checks++;
      if (data !== e) begin
        errors++;
        $display("FAIL live t=%0t sel=%0d up=%0d: data=%h expected %h",
                 $time, timer, upper, data, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] t, input logic u,
                    input logic [31:0] v, input string nm);
    timer = t;
    upper = u;
    #1;
    req_val = v;
    req_nm = nm;
    req_id++;
    #1;
  endtask

  task automatic wr(input logic [1:0] t, input logic u, input logic [31:0] v);
    wr_en = 1'b1;
    wr_timer = t;
    wr_upper = u;
    wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b1;
    tick();
    tick();
    rd(2'd0, 1'b0, 32'd0, "reset_cycle");
    rd(2'd1, 1'b1, 32'd0, "reset_time_hi");
    reset = 1'b0;
    rd(2'd0, 1'b0, 32'd0, "sel0_lo_pre");
    repeat (10) tick();
    rd(2'd0, 1'b0, 32'd10, "cycle_10");
    rd(2'd1, 1'b0, 32'd2, "time_div4");
    rd(2'd2, 1'b0, 32'd0, "instret_0");

    for (int i = 0; i < 5; i++) begin
      instr_retired = 1'b1;
      halt = (i == 1 || i == 3);
      tick();
    end
    instr_retired = 1'b0;
    halt = 1'b0;
    rd(2'd2, 1'b0, 32'd3, "instret_halt");
    rd(2'd0, 1'b0, 32'd13, "cycle_halt");

    wr(2'd0, 1'b1, 32'd0);
    wr(2'd0, 1'b0, 32'hFFFF_FFFE);
    rd(2'd0, 1'b0, 32'hFFFF_FFFE, "wr_cycle_lo");
    tick();
    rd(2'd0, 1'b0, 32'hFFFF_FFFF, "cycle_inc");
    tick();
    rd(2'd0, 1'b0, 32'd0, "carry_lo");
`ifdef SYS_TIMER_SNAPSHOT_EN
    rd(2'd0, 1'b1, 32'd0, "carry_hi_shadow");
`else
    rd(2'd0, 1'b1, 32'd1, "carry_hi");
`endif

    wr(2'd2, 1'b1, 32'hFFFF_FFFF);
    wr(2'd2, 1'b0, 32'hFFFF_FFFF);
    instr_retired = 1'b1;
    tick();
    instr_retired = 1'b0;
    rd(2'd2, 1'b0, 32'd0, "instret_wrap_lo");
`ifdef SYS_TIMER_SNAPSHOT_EN
    rd(2'd2, 1'b1, 32'hFFFF_FFFF, "instret_wrap_shadow");
`else
    rd(2'd2, 1'b1, 32'd0, "instret_wrap_hi");
`endif

    timer = 2'd3;
    upper = 1'b0;
    wr(2'd0, 1'b1, 32'd0);
    wr(2'd0, 1'b0, 32'hFFFF_FFFF);
    rd(2'd3, 1'b0, 32'd0, "reserved_sel");
    rd(2'd0, 1'b0, 32'hFFFF_FFFF, "snap_lo");
    tick();
`ifdef SYS_TIMER_SNAPSHOT_EN
    rd(2'd0, 1'b1, 32'd0, "snap_hi_shadow");
`else
    rd(2'd0, 1'b1, 32'd1, "snap_hi_live");
`endif

    wr(2'd1, 1'b0, 32'd100);
    rd(2'd1, 1'b0, 32'd100, "time_wr_0");
    for (int i = 1; i < 4; i++) begin
      tick();
      rd(2'd1, 1'b0, 32'd100, "time_wr_hold");
    end
    tick();
    rd(2'd1, 1'b0, 32'd101, "time_wr_101");

    reset = 1'b1;
    rd(2'd0, 1'b0, 32'd0, "async_rst_cycle");
    rd(2'd1, 1'b0, 32'd0, "async_rst_time");
    tick();
    reset = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      tick();
      reset = ($urandom_range(0, 399) == 0);
      instr_retired = 1'($urandom_range(0, 1));
      halt = ($urandom_range(0, 3) == 0);
      wr_en = ($urandom_range(0, 7) == 0);
      wr_timer = 2'($urandom_range(0, 3));
      wr_upper = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        wr_data = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        wr_data = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        timer = 2'($urandom_range(0, 3));
        upper = 1'($urandom_range(0, 1));
      end
    end
    tick();
    reset = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
